bin2bcd_conv: RTL and testbench

- Memory-mapped peripheral directly downstream of the 16x16 multiplier in the calculator datapath.
- Software reads the 32-bit product, writes it here, and reads back packed BCD digits for the display driver.
- Conversion is sequential double-dabble: one shift per clock, WIDTH cycles per conversion.
- Register map and read/write style match the multiplier peripheral:
  - sel with addr 0 is a write strobe.
  - Reads are combinational on addr.

---
 rtl/bin2bcd_conv_pkg.sv | 25 ++
 rtl/bin2bcd_conv_add3.sv | 14 +
 rtl/bin2bcd_conv.sv | 110 +++++++++++
 tb/tb_bin2bcd_conv.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_conv_pkg.sv
// Shared constants and types for the binary-to-BCD conversion peripheral.
package bin2bcd_conv_pkg;

  // Default geometry: 32-bit product in, ten BCD digits out.
  localparam int WIDTH_DEF  = 32;
  localparam int DIGITS_DEF = 10;

  // Register map, shared with the multiplier peripheral's access style.
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RES_LO = 2'd2;
  localparam logic [1:0] ADDR_RES_HI = 2'd3;

  // Status register bit positions.
  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;

  // Converter control state: idle after reset, converting, or holding a result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_conv_add3.sv
// Double-dabble digit corrector: a digit of 5 or more gets +3 before the shift
// so that it carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add 3 to any digit that would overflow past 9 after doubling.
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_conv.sv
// Memory-mapped binary-to-packed-BCD converter. A write to the data register
// starts a sequential double-dabble conversion taking one shift per clock;
// the packed result is readable once done is set.
module bin2bcd_conv
  import bin2bcd_conv_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int HI_W  = BCD_W - 32;

  conv_state_t       state, state_nxt;
  logic              busy, done;
  logic              load, last_shift;

  logic [WIDTH-1:0]  in_reg;
  logic [WIDTH-1:0]  shift_reg;
  logic [BCD_W-1:0]  bcd_reg;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_next;
  logic [BCD_W-1:0]  res_reg;
  logic [CNT_W-1:0]  cnt;

  assign load       = sel && (addr == ADDR_DATA);
  assign last_shift = busy && (cnt == CNT_W'(WIDTH - 1));

  // Per-digit +3 correction applied to the working BCD register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (bcd_reg[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // The top digit never reaches 5 for a full-range input, so its carry-out is dropped.
  assign bcd_next = BCD_W'({bcd_adj, shift_reg[WIDTH-1]});

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a load always (re)starts; the last shift moves to done.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = ST_CONV;
    end else begin
      case (state)
        ST_CONV: if (last_shift) state_nxt = ST_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Status outputs decoded from the control state.
  always_comb begin
    busy = (state == ST_CONV);
    done = (state == ST_DONE);
  end

  // Datapath: load takes precedence over a shift, including the completing one,
  // so a load on the completion edge leaves the result register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg    <= '0;
      shift_reg <= '0;
      bcd_reg   <= '0;
      res_reg   <= '0;
      cnt       <= '0;
    end else if (load) begin
      in_reg    <= data_in[WIDTH-1:0];
      shift_reg <= data_in[WIDTH-1:0];
      bcd_reg   <= '0;
      cnt       <= '0;
    end else if (busy) begin
      bcd_reg   <= bcd_next;
      shift_reg <= shift_reg << 1;
      cnt       <= cnt + CNT_W'(1);
      if (last_shift) res_reg <= bcd_next;
    end
  end

  // Combinational register read mux.
  always_comb begin
    data_out = '0;
    case (addr)
      ADDR_DATA:   data_out = 32'(in_reg);
      ADDR_STATUS: begin
        data_out[BUSY_BIT] = busy;
        data_out[DONE_BIT] = done;
      end
      ADDR_RES_LO: data_out = res_reg[31:0];
      ADDR_RES_HI: data_out = 32'(res_reg[32 +: HI_W]);
      default:     data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Bench for bin2bcd_conv: directed register-map scenarios plus randomized
// conversions, checked against a decimal-arithmetic reference model.
module tb_bin2bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [39:0] exp_res;
  logic [31:0] exp_in;

  bin2bcd_conv #(.WIDTH(32), .DIGITS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #10 clk = ~clk;

  // Reference: peel decimal digits off with /10 and %10.
  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    logic [39:0]     r;
    longint unsigned x;
    r = '0;
    x = longint'(v);
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  // One write strobe; returns 1 time unit after the active edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1;
    addr = a;
    data_in = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    data_in = $urandom;
    if (a == 2'd0) exp_in = d;
  endtask

  task automatic rd_all_zero(input string tag);
    rd({tag, "_a0"}, 2'd0, 32'h0);
    rd({tag, "_a1"}, 2'd1, 32'h0);
    rd({tag, "_a2"}, 2'd2, 32'h0);
    rd({tag, "_a3"}, 2'd3, 32'h0);
  endtask

  // Load v and follow it to completion, checking busy and the held result at
  // edge mid (1..31) and E31, then status/result at E32.
  task automatic run_conv(input logic [31:0] v, input int mid);
    wr(2'd0, v);
    rd("st_e0", 2'd1, 32'h1);
    rd("in_e0", 2'd0, v);
    rd("lo_hold_e0", 2'd2, exp_res[31:0]);
    repeat (mid) @(posedge clk);
    #1;
    rd("st_mid", 2'd1, 32'h1);
    rd("lo_hold_mid", 2'd2, exp_res[31:0]);
    rd("hi_hold_mid", 2'd3, {24'h0, exp_res[39:32]});
    if (mid < 31) begin
      repeat (31 - mid) @(posedge clk);
      #1;
      rd("st_e31", 2'd1, 32'h1);
    end
    @(posedge clk);
    #1;
    exp_res = to_bcd(v);
    rd("st_e32", 2'd1, 32'h2);
    rd("lo_e32", 2'd2, exp_res[31:0]);
    rd("hi_e32", 2'd3, {24'h0, exp_res[39:32]});
    rd("in_e32", 2'd0, exp_in);
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; sel = 1'b0; addr = 2'd0; data_in = 32'h0;
    exp_res = '0; exp_in = '0;

    repeat (3) @(posedge clk);
    #1;
    rd_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_conv(32'd0, 16);
    run_conv(32'd83810205, 5);
    run_conv(32'hFFFF_FFFF, 31);

    // Restart while busy: load 1000, reload 7 at E10.
    wr(2'd0, 32'd1000);
    repeat (9) @(posedge clk);
    #1;
    rd("st_restart", 2'd1, 32'h1);
    run_conv(32'd7, 22);

    // Load coinciding with completion: load wins, result untouched.
    wr(2'd0, 32'd12345);
    repeat (31) @(posedge clk);
    run_conv(32'd678, 1);

    // Reset in the middle of a conversion.
    run_conv(32'd99, 10);
    wr(2'd0, 32'd55);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_res = '0;
    exp_in = '0;
    rd_all_zero("midrst");
    rst = 1'b0;
    run_conv(32'd5, 20);

    // Writes to non-data addresses during busy are ignored.
    wr(2'd0, 32'd42);
    wr(2'd1, 32'h1234);
    wr(2'd2, 32'h1234);
    wr(2'd3, 32'h1234);
    repeat (28) @(posedge clk);
    #1;
    rd("st_ign_e31", 2'd1, 32'h1);
    @(posedge clk);
    #1;
    exp_res = to_bcd(32'd42);
    rd("st_ign", 2'd1, 32'h2);
    rd("lo_ign", 2'd2, 32'h0000_0042);
    rd("hi_ign", 2'd3, 32'h0);
    rd("in_ign", 2'd0, 32'h0000_002A);

    // Randomized conversions, some preceded by an aborted load.
    for (int i = 0; i < 12; i++) begin
      v = (i % 2 == 0) ? $urandom : $urandom_range(0, 9999);
      if ($urandom_range(0, 2) == 0) begin
        wr(2'd0, $urandom);
        repeat ($urandom_range(0, 30)) @(posedge clk);
      end
      run_conv(v, $urandom_range(1, 31));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      rd("st_done_hold", 2'd1, 32'h2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
